// File: rtl/alpha_mem_arb.sv
// Single-port memory arbiter/sequencer shared by Icache fetch and Mbox data paths.
// Optional anti-starvation forced fetch grant: define ALPHA_MEM_ARB_STARVE_EN.
module alpha_mem_arb #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [LAT_W-1:0]  r_lat;
  logic              r_owner_if;
  logic              r_is_store;
  logic              r_if_gnt, r_d_gnt, r_if_valid, r_d_valid;
  logic              r_mem_en, r_mem_we, r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic              w_force;
  logic              w_pick_if;
  logic              w_any;

`ifdef ALPHA_MEM_ARB_STARVE_EN
  logic [3:0] r_starve;
  assign w_force = (r_starve == 4'(STARVE_MAX));
`else
  // STARVE_MAX is legal only from 1 upward, so this is strict data priority.
  assign w_force = (STARVE_MAX < 1);
`endif

  assign w_pick_if = if_req && (!d_req || w_force);
  assign w_any     = if_req || d_req;

  // Output registers are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_owner_if  <= 1'b0;
      r_is_store  <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
`ifdef ALPHA_MEM_ARB_STARVE_EN
      r_starve    <= '0;
`endif
    end else begin
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_any) begin
            r_state    <= ISSUE;
            r_busy     <= 1'b1;
            r_owner_if <= w_pick_if;
            r_is_store <= !w_pick_if && d_we;
            r_mem_en   <= 1'b1;
            r_mem_we   <= !w_pick_if && d_we;
            r_mem_addr <= w_pick_if ? if_addr : d_addr;
            if (!w_pick_if) r_mem_wdata <= d_wdata;
            r_if_gnt   <= w_pick_if;
            r_d_gnt    <= !w_pick_if;
`ifdef ALPHA_MEM_ARB_STARVE_EN
            if (w_pick_if)
              r_starve <= '0;
            else if (if_req && (r_starve != 4'(STARVE_MAX)))
              r_starve <= r_starve + 4'd1;
`endif
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_lat   <= LAT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (r_lat == '0) begin
            if (r_owner_if)
              r_if_rdata <= mem_rdata;
            else if (!r_is_store)
              r_d_rdata <= mem_rdata;
            r_if_valid <= r_owner_if;
            r_d_valid  <= !r_owner_if;
            r_state    <= RESP;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alpha_mem_arb.sv
// Directed self-checking bench for alpha_mem_arb (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_alpha_mem_arb;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LAT = 2;
  localparam logic [DW-1:0] POISON = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rstN;
  logic ifReq, dReq, dWe;
  logic [AW-1:0] ifAddr, dAddr;
  logic [DW-1:0] dWdata;
  logic ifGnt, ifValid, dGnt, dValid, memEn, memWe, busy;
  logic [DW-1:0] ifRdata, dRdata, memWdata, memRdata;
  logic [AW-1:0] memAddr;

  logic ifReq1, dReq1;
  logic [AW-1:0] ifAddr1, dAddr1;
  logic ifGnt1, ifValid1, dGnt1, dValid1, memEn1, memWe1, busy1;
  logic [DW-1:0] ifRdata1, dRdata1, memWdata1, memRdata1;
  logic [AW-1:0] memAddr1;

  int nChecks = 0;
  int nErrors = 0;
  logic [31:0] vIfGnt, vDGnt, vIfVal, vDVal, vMemEn, vMemWe, vBusy;

  always #5 clk = ~clk;

  alpha_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rstN),
    .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_valid(ifValid), .if_rdata(ifRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_gnt(dGnt), .d_valid(dValid), .d_rdata(dRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy));

  alpha_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst_n(rstN),
    .if_req(ifReq1), .if_addr(ifAddr1), .if_gnt(ifGnt1), .if_valid(ifValid1), .if_rdata(ifRdata1),
    .d_req(dReq1), .d_we(1'b0), .d_addr(dAddr1), .d_wdata('0),
    .d_gnt(dGnt1), .d_valid(dValid1), .d_rdata(dRdata1),
    .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_rdata(memRdata1), .busy(busy1));

  // Memory model: fixed contents plus the most recent store.
  logic [AW-1:0] lastStAddr;
  logic [DW-1:0] lastStData;
  logic lastStValid;

  function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
    if (lastStValid && a == lastStAddr) return lastStData;
    case (a)
      64'h100: return 64'hAAAA;
      64'h180: return 64'hBBBB;
      64'h200: return 64'h2222;
      default: return {32'hD0D0_0000, a[31:0]};
    endcase
  endfunction

  logic [DW-1:0] rdPipe [LAT];
  logic rdVld [LAT];
  logic [DW-1:0] rdPipe1;
  logic rdVld1;

  always @(posedge clk) begin
    if (!rstN) begin
      lastStValid <= 1'b0;
      lastStAddr  <= '0;
      lastStData  <= '0;
    end else if (memEn && memWe) begin
      lastStValid <= 1'b1;
      lastStAddr  <= memAddr;
      lastStData  <= memWdata;
    end
    rdVld[0]  <= memEn && !memWe;
    rdPipe[0] <= memRead(memAddr);
    for (int i = 1; i < LAT; i++) begin
      rdVld[i]  <= rdVld[i-1];
      rdPipe[i] <= rdPipe[i-1];
    end
    rdVld1  <= memEn1 && !memWe1;
    rdPipe1 <= memRead(memAddr1);
  end

  assign memRdata  = rdVld[LAT-1] ? rdPipe[LAT-1] : POISON;
  assign memRdata1 = rdVld1 ? rdPipe1 : POISON;

  task automatic clearVectors();
    vIfGnt = '0; vDGnt = '0; vIfVal = '0; vDVal = '0;
    vMemEn = '0; vMemWe = '0; vBusy = '0;
  endtask

  task automatic sampleMain(input int c);
    vIfGnt[c] = ifGnt; vDGnt[c] = dGnt; vIfVal[c] = ifValid; vDVal[c] = dValid;
    vMemEn[c] = memEn; vMemWe[c] = memWe; vBusy[c] = busy;
  endtask

  task automatic drain(input int n);
    ifReq = 1'b0; dReq = 1'b0; dWe = 1'b0; ifReq1 = 1'b0; dReq1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    drain(3);
    nChecks++;
    if ({ifGnt, ifValid, dGnt, dValid, memEn, memWe, busy} !== 7'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_ctrl got %b want 0000000", {ifGnt, ifValid, dGnt, dValid, memEn, memWe, busy});
    end
    nChecks++;
    if ({ifRdata, dRdata, memAddr, memWdata} !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_data got if=%h d=%h a=%h w=%h want all 0", ifRdata, dRdata, memAddr, memWdata);
    end
    rstN = 1'b1;
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_idle got busy=%b busy1=%b want 0 0", busy, busy1);
    end
  endtask

  task automatic test_lone_fetch();
    logic [AW-1:0] addr1;
    clearVectors();
    addr1 = '0;
    ifReq = 1'b1; ifAddr = 64'h100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (c == 1) begin addr1 = memAddr; ifReq = 1'b0; end
    end
    nChecks++;
    if (vIfGnt !== 32'h2 || vMemEn !== 32'h2) begin
      nErrors++;
      $display("[TB] FAIL fetch_gnt got gnt=%h en=%h want 2 2", vIfGnt, vMemEn);
    end
    nChecks++;
    if (vIfVal !== 32'h10 || vDVal !== 32'h0) begin
      nErrors++;
      $display("[TB] FAIL fetch_valid got if=%h d=%h want 10 0", vIfVal, vDVal);
    end
    nChecks++;
    if (ifRdata !== 64'hAAAA || addr1 !== 64'h100) begin
      nErrors++;
      $display("[TB] FAIL fetch_data got rdata=%h addr=%h want aaaa 100", ifRdata, addr1);
    end
    nChecks++;
    if (vBusy !== 32'h1E) begin
      nErrors++;
      $display("[TB] FAIL fetch_busy got %h want 1e", vBusy);
    end
  endtask

  task automatic test_priority();
    clearVectors();
    ifReq = 1'b1; ifAddr = 64'h180;
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h200;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (dGnt) dReq = 1'b0;
      if (ifGnt) ifReq = 1'b0;
      if (c == 4) begin
        nChecks++;
        if (dRdata !== 64'h2222) begin
          nErrors++;
          $display("[TB] FAIL prio_drdata got %h want 2222", dRdata);
        end
      end
    end
    nChecks++;
    if (vDGnt !== 32'h2 || vDVal !== 32'h10) begin
      nErrors++;
      $display("[TB] FAIL prio_data got gnt=%h val=%h want 2 10", vDGnt, vDVal);
    end
    nChecks++;
    if (vIfGnt !== 32'h20 || vIfVal !== 32'h100 || vMemEn !== 32'h22) begin
      nErrors++;
      $display("[TB] FAIL prio_fetch got gnt=%h val=%h en=%h want 20 100 22", vIfGnt, vIfVal, vMemEn);
    end
    nChecks++;
    if (ifRdata !== 64'hBBBB) begin
      nErrors++;
      $display("[TB] FAIL prio_ifrdata got %h want bbbb", ifRdata);
    end
  endtask

  task automatic test_store();
    logic [DW-1:0] wd1;
    clearVectors();
    wd1 = '0;
    dReq = 1'b1; dWe = 1'b1; dAddr = 64'h300; dWdata = 64'h55;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (c == 1) begin wd1 = memWdata; dReq = 1'b0; end
    end
    nChecks++;
    if (vMemWe !== 32'h2 || vMemEn !== 32'h2 || wd1 !== 64'h55) begin
      nErrors++;
      $display("[TB] FAIL store_issue got we=%h en=%h wdata=%h want 2 2 55", vMemWe, vMemEn, wd1);
    end
    nChecks++;
    if (vDVal !== 32'h10 || vDGnt !== 32'h2) begin
      nErrors++;
      $display("[TB] FAIL store_ack got val=%h gnt=%h want 10 2", vDVal, vDGnt);
    end
    nChecks++;
    if (dRdata !== 64'h2222) begin
      nErrors++;
      $display("[TB] FAIL store_rdata_hold got %h want 2222", dRdata);
    end
  endtask

  task automatic test_back_to_back();
    clearVectors();
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h300;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (c == 12) dReq = 1'b0;
    end
    nChecks++;
    if (vMemEn !== 32'h222 || vDGnt !== 32'h222) begin
      nErrors++;
      $display("[TB] FAIL b2b_issue got en=%h gnt=%h want 222 222", vMemEn, vDGnt);
    end
    nChecks++;
    if (vDVal !== 32'h1110 || vBusy !== 32'h1FFE) begin
      nErrors++;
      $display("[TB] FAIL b2b_valid got val=%h busy=%h want 1110 1ffe", vDVal, vBusy);
    end
    nChecks++;
    if (dRdata !== 64'h55) begin
      nErrors++;
      $display("[TB] FAIL b2b_load_after_store got %h want 55", dRdata);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] expD, expI;
`ifdef ALPHA_MEM_ARB_STARVE_EN
    expD = 32'h2220_2222; expI = 32'h0002_0000;
`else
    expD = 32'h2222_2222; expI = 32'h0;
`endif
    clearVectors();
    ifReq = 1'b1; ifAddr = 64'h180;
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h200;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      sampleMain(c);
    end
    drain(8);
    nChecks++;
    if (vDGnt !== expD) begin
      nErrors++;
      $display("[TB] FAIL starve_dgnt got %h want %h", vDGnt, expD);
    end
    nChecks++;
    if (vIfGnt !== expI) begin
      nErrors++;
      $display("[TB] FAIL starve_ifgnt got %h want %h", vIfGnt, expI);
    end
  endtask

  task automatic test_reset_in_flight();
    clearVectors();
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h200;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (c == 1) dReq = 1'b0;
      if (c == 2) rstN = 1'b0;
      if (c == 3) rstN = 1'b1;
    end
    nChecks++;
    if (vDVal !== 32'h0 || vIfVal !== 32'h0) begin
      nErrors++;
      $display("[TB] FAIL rst_flight_valid got d=%h if=%h want 0 0", vDVal, vIfVal);
    end
    nChecks++;
    if (vBusy !== 32'h6 || vDGnt !== 32'h2) begin
      nErrors++;
      $display("[TB] FAIL rst_flight_busy got busy=%h gnt=%h want 6 2", vBusy, vDGnt);
    end
    nChecks++;
    if (dRdata !== 64'h0 || ifRdata !== 64'h0) begin
      nErrors++;
      $display("[TB] FAIL rst_flight_rdata got d=%h if=%h want 0 0", dRdata, ifRdata);
    end
    clearVectors();
    ifReq = 1'b1; ifAddr = 64'h100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      sampleMain(c);
      if (c == 1) ifReq = 1'b0;
    end
    nChecks++;
    if (vIfGnt !== 32'h2 || vIfVal !== 32'h10 || ifRdata !== 64'hAAAA) begin
      nErrors++;
      $display("[TB] FAIL rst_fresh got gnt=%h val=%h rdata=%h want 2 10 aaaa", vIfGnt, vIfVal, ifRdata);
    end
  endtask

  task automatic test_lat1();
    logic [31:0] vEn1, vVal1;
    vEn1 = '0; vVal1 = '0;
    dReq1 = 1'b1; dAddr1 = 64'h200;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      vEn1[c] = memEn1; vVal1[c] = dValid1;
      if (c == 12) dReq1 = 1'b0;
    end
    nChecks++;
    if (vEn1 !== 32'h492) begin
      nErrors++;
      $display("[TB] FAIL lat1_mem_en got %h want 492", vEn1);
    end
    nChecks++;
    if (vVal1 !== 32'h1248) begin
      nErrors++;
      $display("[TB] FAIL lat1_valid got %h want 1248", vVal1);
    end
    nChecks++;
    if (dRdata1 !== 64'h2222 || ifValid1 !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL lat1_rdata got %h ifv=%b want 2222 0", dRdata1, ifValid1);
    end
  endtask

  initial begin
    ifReq = 1'b0; dReq = 1'b0; dWe = 1'b0; ifAddr = '0; dAddr = '0; dWdata = '0;
    ifReq1 = 1'b0; dReq1 = 1'b0; ifAddr1 = '0; dAddr1 = '0;
    rstN = 1'b0;
    clearVectors();
    test_reset();
    test_lone_fetch();
    drain(2);
    test_priority();
    drain(2);
    test_store();
    drain(2);
    test_back_to_back();
    drain(4);
    test_starvation();
    test_reset_in_flight();
    drain(2);
    test_lat1();
    drain(2);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
